// File: rtl/dm_pkg.sv
// Shared encodings for the dm_pipe data memory: load/store widths, FSM states
// and the store byte-enable helper.
package dm_pkg;

  typedef enum logic [2:0] {
    LS_W  = 3'b000,
    LS_H  = 3'b001,
    LS_HU = 3'b010,
    LS_B  = 3'b011,
    LS_BU = 3'b100
  } lstype_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Byte lanes touched by a store of the given width at byte offset off.
  function automatic logic [3:0] byte_en(input logic [2:0] ls, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (ls)
      LS_W:    be = 4'b1111;
      LS_H:    be = off[1] ? 4'b1100 : 4'b0011;
      LS_B:    be = 4'b0001 << off;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_bram.sv
// Single-port 32-bit word memory with per-byte write enables, synchronous write
// and a registered read port (read returns the pre-write contents).
module dm_bram
  import dm_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_pipe.sv
// Data memory front end: clears the array after reset, then accepts one
// load/store per cycle with alignment/range fault detection and load extension.
module dm_pipe
  import dm_pkg::*;
#(
  parameter int WORDS_LOG2 = 10,
  parameter int FAULT_OOR  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        WE,
  input  logic [2:0]  LStype,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic        Ready,
  output logic        Busy,
  output logic [31:0] RD,
  output logic        RDValid,
  output logic        AdEL,
  output logic        AdES
);

  localparam logic [WORDS_LOG2-1:0] LAST_IDX = '1;

  state_e                state_q, state_d;
  logic [WORDS_LOG2-1:0] idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic [31:0]           rd_q, rd_d;
  logic                  rdvalid_q, rdvalid_d;
  logic                  adel_q, adel_d;
  logic                  ades_q, ades_d;
  logic                  ld_vld_p1_q, ld_vld_p1_d;
  logic                  adel_p1_q, adel_p1_d;
  logic                  ades_p1_q, ades_p1_d;
  logic [2:0]            ls_p1_q, ls_p1_d;
  logic [1:0]            off_p1_q, off_p1_d;

  logic                  accept;
  logic                  misalign, bad_type, oor, fault;
  logic [31:0]           st_data;
  logic                  mem_en;
  logic [3:0]            mem_we;
  logic [WORDS_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] ls,
                                              input logic [1:0] off);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = off[1] ? w[31:16] : w[15:0];
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    case (ls)
      LS_H:    r = {{16{h[15]}}, h};
      LS_HU:   r = {16'h0000, h};
      LS_B:    r = {{24{b[7]}}, b};
      LS_BU:   r = {24'h000000, b};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept = Req && ready_q && !Reset;

  always_comb begin
    misalign = 1'b0;
    case (LStype)
      LS_W:        misalign = (Addr[1:0] != 2'b00);
      LS_H, LS_HU: misalign = Addr[0];
      default:     misalign = 1'b0;
    endcase
    // Unsigned widths only make sense for loads.
    bad_type = (LStype > LS_BU) || (WE && (LStype == LS_HU || LStype == LS_BU));
    oor      = (FAULT_OOR != 0) && ((Addr >> (WORDS_LOG2 + 2)) != 32'd0);
    fault    = misalign || bad_type || oor;
  end

  always_comb begin
    case (LStype)
      LS_B:    st_data = {4{WD[7:0]}};
      LS_H:    st_data = {2{WD[15:0]}};
      default: st_data = WD;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = Addr[WORDS_LOG2+1:2];
    mem_wdata = st_data;
    if (state_q == ST_CLEAR) begin
      mem_en    = 1'b1;
      mem_we    = 4'b1111;
      mem_addr  = idx_q;
      mem_wdata = 32'h0;
    end else if (accept) begin
      mem_en = 1'b1;
      mem_we = (WE && !fault) ? byte_en(LStype, Addr[1:0]) : 4'b0000;
    end
  end

  dm_bram #(.AW(WORDS_LOG2)) u_bram (
    .clk   (Clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rd_d        = rd_q;
    rdvalid_d   = 1'b0;
    adel_d      = 1'b0;
    ades_d      = 1'b0;
    ld_vld_p1_d = accept && !WE && !fault;
    adel_p1_d   = accept && !WE && fault;
    ades_p1_d   = accept && WE && fault;
    ls_p1_d     = LStype;
    off_p1_d    = Addr[1:0];
    if (state_q == ST_CLEAR) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    end else begin
      // Faults share the load result stage so the three pulses never overlap.
      rdvalid_d = ld_vld_p1_q;
      adel_d    = adel_p1_q;
      ades_d    = ades_p1_q;
      if (ld_vld_p1_q) rd_d = load_extend(mem_rdata, ls_p1_q, off_p1_q);
    end
  end

  // Stage p1 holds the accepted access; stage p2 drives the result outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rd_q        <= 32'h0;
      rdvalid_q   <= 1'b0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      ld_vld_p1_q <= 1'b0;
      adel_p1_q   <= 1'b0;
      ades_p1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
      rdvalid_q   <= rdvalid_d;
      adel_q      <= adel_d;
      ades_q      <= ades_d;
      ld_vld_p1_q <= ld_vld_p1_d;
      adel_p1_q   <= adel_p1_d;
      ades_p1_q   <= ades_p1_d;
    end
    ls_p1_q  <= ls_p1_d;
    off_p1_q <= off_p1_d;
  end

  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign RD      = rd_q;
  assign RDValid = rdvalid_q;
  assign AdEL    = adel_q;
  assign AdES    = ades_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Directed bench for dm_pipe: table of single accesses plus reset/sweep and
// back-to-back sequences, all with hand-computed expectations.
module tb_dm_pipe;
  import dm_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_EL   = 2;
  localparam int K_ES   = 3;
  localparam int NVEC   = 36;

  typedef struct {
    logic        we;
    logic [2:0]  ls;
    logic [31:0] addr;
    logic [31:0] wd;
    int          kind;
    logic [31:0] rd;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        WE = 1'b0;
  logic [2:0]  LStype = 3'b000;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WD = 32'h0;
  logic        Ready, Busy, RDValid, AdEL, AdES;
  logic [31:0] RD;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = 32'h0;
  vec_t        vt [NVEC];

  dm_pipe #(.WORDS_LOG2(10), .FAULT_OOR(1)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Req     (Req),
    .WE      (WE),
    .LStype  (LStype),
    .Addr    (Addr),
    .WD      (WD),
    .Ready   (Ready),
    .Busy    (Busy),
    .RD      (RD),
    .RDValid (RDValid),
    .AdEL    (AdEL),
    .AdES    (AdES)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic we, input logic [2:0] ls, input logic [31:0] a,
                              input logic [31:0] wd, input int kind, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.ls = ls; v.addr = a; v.wd = wd; v.kind = kind; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Counts rising edges after Reset is released until Ready is seen high.
  task automatic wait_ready(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(posedge Clk);
      n++;
      #1;
      if (Ready) seen = 1'b1;
    end
    check(name, 64'(n), 64'd1024);
    @(negedge Clk);
    check({name, "_flags"}, {62'd0, Ready, Busy}, 64'b10);
  endtask

  // Starts and ends on a falling edge; accept edge T, result checked after T+1.
  task automatic access(input vec_t v, input string name);
    logic [34:0] exp;
    Req = 1'b1; WE = v.we; LStype = v.ls; Addr = v.addr; WD = v.wd;
    @(negedge Clk);
    Req = 1'b0;
    check({name, "_lat"}, {61'd0, RDValid, AdEL, AdES}, 64'd0);
    @(negedge Clk);
    case (v.kind)
      K_RD:    exp = {3'b100, v.rd};
      K_EL:    exp = {3'b010, last_rd};
      K_ES:    exp = {3'b001, last_rd};
      default: exp = {3'b000, last_rd};
    endcase
    check(name, {29'd0, RDValid, AdEL, AdES, RD}, {29'd0, exp});
    if (v.kind == K_RD) last_rd = v.rd;
  endtask

  initial begin
    int   cnt;
    bit   stray;
    vt[0]  = mk(0, LS_W,  32'h0000_0000, 32'h0,          K_RD,   32'h0000_0000);
    vt[1]  = mk(1, LS_W,  32'h0000_0010, 32'h1122_3344,  K_NONE, 32'h0);
    vt[2]  = mk(0, LS_B,  32'h0000_0013, 32'h0,          K_RD,   32'h0000_0011);
    vt[3]  = mk(0, LS_BU, 32'h0000_0012, 32'h0,          K_RD,   32'h0000_0022);
    vt[4]  = mk(0, LS_H,  32'h0000_0010, 32'h0,          K_RD,   32'h0000_3344);
    vt[5]  = mk(0, LS_B,  32'h0000_0010, 32'h0,          K_RD,   32'h0000_0044);
    vt[6]  = mk(0, LS_W,  32'h0000_0010, 32'h0,          K_RD,   32'h1122_3344);
    vt[7]  = mk(1, LS_W,  32'h0000_0014, 32'hCAFE_BABE,  K_NONE, 32'h0);
    vt[8]  = mk(1, LS_H,  32'h0000_0016, 32'h1234_8001,  K_NONE, 32'h0);
    vt[9]  = mk(0, LS_H,  32'h0000_0016, 32'h0,          K_RD,   32'hFFFF_8001);
    vt[10] = mk(0, LS_HU, 32'h0000_0016, 32'h0,          K_RD,   32'h0000_8001);
    vt[11] = mk(0, LS_W,  32'h0000_0014, 32'h0,          K_RD,   32'h8001_BABE);
    vt[12] = mk(1, LS_B,  32'h0000_0015, 32'hFFFF_FF77,  K_NONE, 32'h0);
    vt[13] = mk(0, LS_W,  32'h0000_0014, 32'h0,          K_RD,   32'h8001_77BE);
    vt[14] = mk(0, LS_BU, 32'h0000_0017, 32'h0,          K_RD,   32'h0000_0080);
    vt[15] = mk(0, LS_B,  32'h0000_0017, 32'h0,          K_RD,   32'hFFFF_FF80);
    vt[16] = mk(0, LS_W,  32'h0000_0002, 32'h0,          K_EL,   32'h0);
    vt[17] = mk(1, LS_H,  32'h0000_0005, 32'h0000_1234,  K_ES,   32'h0);
    vt[18] = mk(0, LS_W,  32'h0000_0004, 32'h0,          K_RD,   32'h0000_0000);
    vt[19] = mk(1, LS_W,  32'h0000_1000, 32'h5555_AAAA,  K_ES,   32'h0);
    vt[20] = mk(0, LS_W,  32'h0000_0000, 32'h0,          K_RD,   32'h0000_0000);
    vt[21] = mk(0, LS_W,  32'h0000_1000, 32'h0,          K_EL,   32'h0);
    vt[22] = mk(1, LS_HU, 32'h0000_0008, 32'h0000_FFFF,  K_ES,   32'h0);
    vt[23] = mk(1, LS_BU, 32'h0000_0008, 32'h0000_00FF,  K_ES,   32'h0);
    vt[24] = mk(0, LS_W,  32'h0000_0008, 32'h0,          K_RD,   32'h0000_0000);
    vt[25] = mk(0, 3'b101, 32'h0000_0008, 32'h0,         K_EL,   32'h0);
    vt[26] = mk(1, 3'b111, 32'h0000_0008, 32'h0000_0001, K_ES,   32'h0);
    vt[27] = mk(0, LS_H,  32'h0000_0011, 32'h0,          K_EL,   32'h0);
    vt[28] = mk(0, LS_B,  32'h0000_0011, 32'h0,          K_RD,   32'h0000_0033);
    vt[29] = mk(1, LS_W,  32'h0000_0FFC, 32'hDEAD_BEEF,  K_NONE, 32'h0);
    vt[30] = mk(0, LS_HU, 32'h0000_0FFE, 32'h0,          K_RD,   32'h0000_DEAD);
    vt[31] = mk(0, LS_BU, 32'h0000_0FFD, 32'h0,          K_RD,   32'h0000_00BE);
    vt[32] = mk(0, LS_W,  32'h0000_0012, 32'h0,          K_EL,   32'h0);
    vt[33] = mk(1, LS_W,  32'h0000_0003, 32'h0000_0009,  K_ES,   32'h0);
    vt[34] = mk(0, LS_HU, 32'h0000_0013, 32'h0,          K_EL,   32'h0);
    vt[35] = mk(0, 3'b110, 32'h0000_0000, 32'h0,         K_EL,   32'h0);

    // Power-on reset and first sweep.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_out", {26'd0, Ready, Busy, RDValid, AdEL, AdES, RD}, {26'd0, 1'b0, 1'b1, 3'b000, 32'h0});
    Reset = 1'b0;
    wait_ready("sweep1");

    for (int i = 0; i < NVEC; i++) access(vt[i], $sformatf("vec%0d", i));

    // Back-to-back: sb, lbu same byte, sw; one RDValid pulse.
    Req = 1'b1; WE = 1'b1; LStype = LS_B; Addr = 32'h20; WD = 32'h0000_00AB;
    @(negedge Clk);
    WE = 1'b0; LStype = LS_BU; Addr = 32'h20;
    check("b2b_t0", {61'd0, RDValid, AdEL, AdES}, 64'd0);
    @(negedge Clk);
    WE = 1'b1; LStype = LS_W; Addr = 32'h24; WD = 32'h0102_0304;
    check("b2b_t1", {63'd0, RDValid}, 64'd0);
    @(negedge Clk);
    Req = 1'b0;
    check("b2b_t2", {31'd0, RDValid, RD}, {31'd0, 1'b1, 32'h0000_00AB});
    @(negedge Clk);
    check("b2b_t3", {61'd0, RDValid, AdEL, AdES}, 64'd0);
    last_rd = 32'h0000_00AB;
    access(mk(0, LS_W, 32'h24, 32'h0, K_RD, 32'h0102_0304), "b2b_sw");
    access(mk(0, LS_W, 32'h20, 32'h0, K_RD, 32'h0000_00AB), "b2b_sb");

    // Store presented with Req low must not write.
    Req = 1'b0; WE = 1'b1; LStype = LS_W; Addr = 32'h30; WD = 32'hFFFF_FFFF;
    repeat (2) @(negedge Clk);
    check("noreq_pulse", {61'd0, RDValid, AdEL, AdES}, 64'd0);
    access(mk(0, LS_W, 32'h30, 32'h0, K_RD, 32'h0), "noreq_mem");

    // Reset in IDLE right after a load accept discards its result.
    Req = 1'b1; WE = 1'b0; LStype = LS_W; Addr = 32'h10;
    @(negedge Clk);
    Req = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    check("rst_discard", {26'd0, Ready, Busy, RDValid, AdEL, AdES, RD}, {26'd0, 1'b0, 1'b1, 3'b000, 32'h0});
    @(negedge Clk);
    check("rst_hold", {62'd0, RDValid, Ready}, 64'd0);

    // Reset again at sweep index 500.
    Reset = 1'b0;
    repeat (500) @(negedge Clk);
    check("mid_busy", {62'd0, Ready, Busy}, 64'b01);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst", {62'd0, Ready, Busy}, 64'b01);
    Reset = 1'b0;

    // Second sweep with a store held on Req late in the sweep (Ready low).
    cnt = 2000;
    stray = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      Req = (c >= 900 && c < 1000); WE = 1'b1; LStype = LS_W; Addr = 32'h0; WD = 32'h5A5A_5A5A;
      @(posedge Clk);
      #1;
      if (RDValid || AdEL || AdES) stray = 1'b1;
      if (Ready) begin
        cnt = c;
        break;
      end
    end
    Req = 1'b0;
    check("sweep2", 64'(cnt), 64'd1024);
    check("sweep2_stray", {63'd0, stray}, 64'd0);
    @(negedge Clk);
    last_rd = 32'h0;
    access(mk(0, LS_W, 32'h00, 32'h0, K_RD, 32'h0), "busy_nowrite");
    access(mk(0, LS_W, 32'h10, 32'h0, K_RD, 32'h0), "cleared_10");
    access(mk(0, LS_W, 32'hFFC, 32'h0, K_RD, 32'h0), "cleared_ffc");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_pipe.md
DM_PIPE -- requirements
Module: dm_pipe

Interface
REQ-001 SHALL have parameter WORDS_LOG2, default 10, giving memory depth as 2**WORDS_LOG2 32-bit words.
REQ-002 SHALL have parameter FAULT_OOR, default 1; when 1, addresses at or above 4*2**WORDS_LOG2 fault; when 0, upper bits are ignored (aliasing).
REQ-003 SHALL have one clock and a synchronous active-high reset: Clk input 1, rising-edge clock; Reset input 1, synchronous active-high reset.
REQ-004 SHALL have port Req, input 1: access request.
REQ-005 SHALL have port WE, input 1: 1 = store, 0 = load.
REQ-006 SHALL have port LStype, input 3: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
REQ-007 SHALL have port Addr, input 32: byte address.
REQ-008 SHALL have port WD, input 32: store data, right-aligned.
REQ-009 SHALL have port Ready, output 1: request accepted this cycle when Req&&Ready.
REQ-010 SHALL have port Busy, output 1: initialisation sweep in progress.
REQ-011 SHALL have port RD, output 32: load result, extended per LStype.
REQ-012 SHALL have port RDValid, output 1: one-cycle pulse, RD valid.
REQ-013 SHALL have port AdEL, output 1: one-cycle pulse, load address fault.
REQ-014 SHALL have port AdES, output 1: one-cycle pulse, store address fault.

Function
REQ-015 SHALL implement FSM states CLEAR and IDLE; Reset forces CLEAR with sweep index 0.
REQ-016 In CLEAR, SHALL write 0 to one word per cycle at index 0..2**WORDS_LOG2-1, hold Busy=1 and Ready=0, then enter IDLE on the cycle after the last word is written.
REQ-017 In IDLE, SHALL hold Ready=1 and Busy=0, and SHALL accept one access per cycle back-to-back.
REQ-018 Alignment faults: word requires Addr[1:0]=00; half requires Addr[0]=0; byte has no alignment requirement.
REQ-019 On an accepted faulting access, SHALL leave memory unchanged and pulse AdEL (load) or AdES (store) the next cycle, with RDValid=0 and RD unchanged.
REQ-020 Stores SHALL accept LStype 000/001/011 only; 010 and 100 on a store SHALL raise AdES.
REQ-021 Any LStype above 100 SHALL raise AdEL or AdES per WE.
REQ-022 Stores SHALL write at the accepting edge using byte enables derived from LStype and Addr[1:0]; WD[7:0] goes to the addressed byte and WD[15:0] to the addressed half; other bytes are preserved.
REQ-023 Loads SHALL have latency 1: accepted at edge T, RD and RDValid=1 valid after edge T+1.
REQ-024 Load extension: half/byte are selected by Addr[1:0]; signed variants sign-extend from the selected MSB; unsigned variants zero-extend.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-026 Non-accepted cycles (Req=0 or Ready=0) SHALL pulse nothing and write nothing.
REQ-027 RDValid, AdEL and AdES SHALL be mutually exclusive.

Reset
REQ-028 During and after Reset, SHALL hold RD=0, RDValid=0, AdEL=0, AdES=0, Ready=0 and Busy=1.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep at index 0.
REQ-030 Reset asserted in IDLE SHALL discard any pending load result, so no RDValid pulse follows.
REQ-031 After Reset deasserts, Ready SHALL rise exactly 2**WORDS_LOG2 cycles later.

Structure
REQ-032 The LStype encodings and the FSM state encoding SHALL live in shared package dm_pkg.
REQ-033 Storage SHALL be the sub-module dm_bram: one-port, 32-bit, 4 byte-enables, synchronous write, registered read; dm_pipe owns the FSM, fault logic, byte-enable generation and extension.

Verification
REQ-034 Reset, then count cycles -> Ready rises 1024 cycles after Reset falls; a load of 0x0 then returns RD=0.
REQ-035 sw 0x11223344 @0x10, then lb @0x13 and lbu @0x12 -> RD=0x00000011, then RD=0x00000022, each 1 cycle after accept.
REQ-036 sh 0x8001 @0x16, then lh @0x16 and lhu @0x16 -> RD=0xFFFF8001 and RD=0x00008001; the word @0x14 bytes [15:0] are unchanged.
REQ-037 lw @0x2 -> AdEL pulse, RDValid=0; sh @0x5 -> AdES pulse, memory unchanged; sw @0x1000 with FAULT_OOR=1 -> AdES.
REQ-038 Reset pulsed at sweep index 500 -> sweep restarts; Ready rises 1024 cycles after the second Reset falls.
REQ-039 Back-to-back: sb 0xAB @0x20, then lbu @0x20 the next cycle, then sw @0x24 -> RD=0x000000AB with RDValid asserted for exactly one cycle.
